// File: rtl/spu_pkg.sv
// Shared SPU definitions: register-file write widths and the write-request payload.
package spu_pkg;

   localparam int REG_ADDR_W = 7;
   localparam int DATA_W     = 128;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rt;
      logic [DATA_W-1:0]     data;
   } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back bus: MEM/WB-stage requests in, register-file write port and status out.
interface wb_port_arbiter_if;
   import spu_pkg::*;

   logic                  mem_valid;
   logic [REG_ADDR_W-1:0] mem_rt;
   logic [DATA_W-1:0]     mem_data;
   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rt;
   logic [DATA_W-1:0]     alu_data;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic                  stall;
   logic                  busy;
   logic                  overflow;

   modport master (
      output mem_valid, mem_rt, mem_data, alu_valid, alu_rt, alu_data,
      input  rf_we, rf_waddr, rf_wdata, stall, busy, overflow
   );

   modport slave (
      input  mem_valid, mem_rt, mem_data, alu_valid, alu_rt, alu_data,
      output rf_we, rf_waddr, rf_wdata, stall, busy, overflow
   );

endinterface

// File: rtl/wb_fifo.sv
// Pending-write FIFO: two ordered push ports (a before b), one pop port, wrap-around pointers.
module wb_fifo
   import spu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_a,
   input  wb_req_t          din_a,
   input  logic             push_b,
   input  wb_req_t          din_b,
   input  logic             pop,
   output wb_req_t          head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   wb_req_t          slots [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_b;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // push_b is only ever raised together with push_a, so it lands in the slot after it.
   assign wr_ptr_b = ptr_inc(wr_ptr);
   assign head     = slots[rd_ptr];
   assign empty    = (count == '0);

   // NOTE: payload storage is deliberately not reset; pointers and count alone define which slots are live.
   always_ff @(posedge clk) begin
      if (push_a) slots[wr_ptr]   <= din_a;
      if (push_b) slots[wr_ptr_b] <= din_b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push_b)      wr_ptr <= ptr_inc(wr_ptr_b);
         else if (push_a) wr_ptr <= wr_ptr_b;
         count <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Merges load and ALU results onto a single register-file write port, preserving program order.
module wb_port_arbiter
   import spu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              reset,
   wb_port_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             mem_ok;
   logic             alu_ok;
   wb_req_t          mem_req;
   wb_req_t          alu_req;
   wb_req_t          sel;
   logic             sel_valid;
   logic             push_a;
   logic             push_b;
   wb_req_t          din_a;
   logic             pop;
   wb_req_t          head;
   logic [CNT_W-1:0] count;
   logic             fifo_empty;
   logic             stall;

   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]     rf_wdata;
   logic                  overflow;

   assign stall  = (int'(count) >= DEPTH - 1);
   assign mem_ok = bus.mem_valid & ~stall;
   assign alu_ok = bus.alu_valid & ~stall;

   assign mem_req = '{rt: bus.mem_rt, data: bus.mem_data};
   assign alu_req = '{rt: bus.alu_rt, data: bus.alu_data};

   // Oldest pending item (FIFO head, then mem, then alu) is written; the rest are queued in order.
   always_comb begin
      sel_valid = 1'b0;
      sel       = '0;
      pop       = 1'b0;
      push_a    = 1'b0;
      push_b    = 1'b0;
      din_a     = alu_req;
      if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel       = head;
         pop       = 1'b1;
         push_a    = mem_ok | alu_ok;
         din_a     = mem_ok ? mem_req : alu_req;
         push_b    = mem_ok & alu_ok;
      end else if (mem_ok) begin
         sel_valid = 1'b1;
         sel       = mem_req;
         push_a    = alu_ok;
      end else if (alu_ok) begin
         sel_valid = 1'b1;
         sel       = alu_req;
      end
   end

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push_a (push_a),
      .din_a  (din_a),
      .push_b (push_b),
      .din_b  (alu_req),
      .pop    (pop),
      .head   (head),
      .count  (count),
      .empty  (fifo_empty)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         overflow <= 1'b0;
      end else begin
         rf_we <= sel_valid;
         if (sel_valid) begin
            rf_waddr <= sel.rt;
            rf_wdata <= sel.data;
         end
         if (stall && (bus.mem_valid || bus.alu_valid)) overflow <= 1'b1;
      end
   end

   assign bus.rf_we    = rf_we;
   assign bus.rf_waddr = rf_waddr;
   assign bus.rf_wdata = rf_wdata;
   assign bus.stall    = stall;
   assign bus.busy     = !fifo_empty || rf_we;
   assign bus.overflow = overflow;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=4): bypass, ordering, stall/overflow and reset drops.
module tb_wb_port_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wb_port_arbiter_if bus ();

   wb_port_arbiter #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mv, input logic [6:0] mrt, input logic [127:0] md,
                        input logic av, input logic [6:0] art, input logic [127:0] ad);
      bus.mem_valid = mv;
      bus.mem_rt    = mrt;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_rt    = art;
      bus.alu_data  = ad;
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 128'd0);
   endtask

   task automatic check_wr(input string tag, input logic [6:0] rt, input logic [127:0] d);
      check({tag, "_we"},   128'(bus.rf_we), 128'd1);
      check({tag, "_addr"}, 128'(bus.rf_waddr), 128'(rt));
      check({tag, "_data"}, bus.rf_wdata, d);
   endtask

   task automatic check_status(input string tag, input int cnt, input logic st, input logic bz);
      check({tag, "_count"}, 128'(dut.u_fifo.count), 128'(cnt));
      check({tag, "_stall"}, 128'(bus.stall), 128'(st));
      check({tag, "_busy"},  128'(bus.busy), 128'(bz));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset cycle with a request present: request must be discarded.
      drive(1'b1, 7'd9, 128'h99, 1'b1, 7'd8, 128'h88);
      tick();
      check("rst_we", 128'(bus.rf_we), 128'd0);
      check("rst_waddr", 128'(bus.rf_waddr), 128'd0);
      check("rst_wdata", bus.rf_wdata, 128'd0);
      check("rst_ovf", 128'(bus.overflow), 128'd0);
      check_status("rst", 0, 1'b0, 1'b0);
      reset = 1'b0;
      idle();
      tick();
      check("rst_discard_we", 128'(bus.rf_we), 128'd0);

      // Single alu request bypasses the FIFO; first request after reset.
      drive(1'b0, 7'd0, 128'd0, 1'b1, 7'd5, {16{8'hA5}});
      tick();
      idle();
      check_wr("bypass", 7'd5, {16{8'hA5}});
      check_status("bypass", 0, 1'b0, 1'b1);
      tick();
      check("idle_we", 128'(bus.rf_we), 128'd0);
      check("idle_hold_addr", 128'(bus.rf_waddr), 128'd5);
      check("idle_hold_data", bus.rf_wdata, {16{8'hA5}});
      check_status("idle", 0, 1'b0, 1'b0);

      // Same rt from both ports: mem first, alu next, youngest value last.
      drive(1'b1, 7'd3, 128'h11, 1'b1, 7'd3, 128'h22);
      tick();
      idle();
      check_wr("same_rt_n1", 7'd3, 128'h11);
      check_status("same_rt_n1", 1, 1'b0, 1'b1);
      tick();
      check_wr("same_rt_n2", 7'd3, 128'h22);
      check_status("same_rt_n2", 0, 1'b0, 1'b1);
      tick();
      check("same_rt_done", 128'(bus.rf_we), 128'd0);

      // Three back-to-back dual requests: count 1,2,3, stall at 3, strict drain order.
      drive(1'b1, 7'd10, 128'h1010, 1'b1, 7'd11, 128'h1011);
      tick();
      check_wr("burst1", 7'd10, 128'h1010);
      check_status("burst1", 1, 1'b0, 1'b1);
      drive(1'b1, 7'd12, 128'h1012, 1'b1, 7'd13, 128'h1013);
      tick();
      check_wr("burst2", 7'd11, 128'h1011);
      check_status("burst2", 2, 1'b0, 1'b1);
      drive(1'b1, 7'd14, 128'h1014, 1'b1, 7'd15, 128'h1015);
      tick();
      idle();
      check_wr("burst3", 7'd12, 128'h1012);
      check_status("burst3", 3, 1'b1, 1'b1);
      tick();
      check_wr("drain1", 7'd13, 128'h1013);
      check_status("drain1", 2, 1'b0, 1'b1);
      tick();
      check_wr("drain2", 7'd14, 128'h1014);
      check_status("drain2", 1, 1'b0, 1'b1);
      tick();
      check_wr("drain3", 7'd15, 128'h1015);
      check_status("drain3", 0, 1'b0, 1'b1);
      tick();
      check("drain_done_we", 128'(bus.rf_we), 128'd0);
      check("drain_no_ovf", 128'(bus.overflow), 128'd0);

      // Fill to stall, then force requests while stalled: they are dropped and overflow sticks.
      drive(1'b1, 7'd21, 128'h21, 1'b1, 7'd22, 128'h22);
      tick();
      drive(1'b1, 7'd23, 128'h23, 1'b1, 7'd24, 128'h24);
      tick();
      drive(1'b1, 7'd25, 128'h25, 1'b1, 7'd26, 128'h26);
      tick();
      check_wr("fill3", 7'd23, 128'h23);
      check_status("fill3", 3, 1'b1, 1'b1);
      drive(1'b1, 7'd30, 128'hBAD, 1'b1, 7'd31, 128'hBAD1);
      tick();
      idle();
      check_wr("stalled", 7'd24, 128'h24);
      check("stalled_ovf", 128'(bus.overflow), 128'd1);
      check_status("stalled", 2, 1'b0, 1'b1);
      tick();
      check_wr("ovf_drain1", 7'd25, 128'h25);
      tick();
      check_wr("ovf_drain2", 7'd26, 128'h26);
      check_status("ovf_drain2", 0, 1'b0, 1'b1);
      tick();
      check("ovf_drain_done", 128'(bus.rf_we), 128'd0);
      check("ovf_sticky", 128'(bus.overflow), 128'd1);

      // Reset with two pending writes: they must never reach the write port.
      drive(1'b1, 7'd40, 128'h40, 1'b1, 7'd41, 128'h41);
      tick();
      drive(1'b1, 7'd42, 128'h42, 1'b1, 7'd43, 128'h43);
      tick();
      check_wr("pre_rst", 7'd41, 128'h41);
      check_status("pre_rst", 2, 1'b0, 1'b1);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_we", 128'(bus.rf_we), 128'd0);
      check("mid_rst_ovf", 128'(bus.overflow), 128'd0);
      check_status("mid_rst", 0, 1'b0, 1'b0);
      tick();
      check("post_rst_we1", 128'(bus.rf_we), 128'd0);
      tick();
      check("post_rst_we2", 128'(bus.rf_we), 128'd0);

      // First request after reset bypasses.
      drive(1'b1, 7'd7, 128'h77, 1'b0, 7'd0, 128'd0);
      tick();
      idle();
      check_wr("post_rst_bypass", 7'd7, 128'h77);
      check_status("post_rst_bypass", 0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
